// File: rtl/pipeline_sequencer.sv
// Pipeline hazard sequencer: branch/jump redirect, load-use interlock and multi-cycle multiply stall.
// Control outputs are combinational from state and inputs; stall/flush statistics are registered.
module pipeline_sequencer #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  OpcodeID,
  input  logic [4:0]  OpCodeIDEXOUT,
  input  logic [4:0]  DirRegA,
  input  logic [4:0]  DirRegB,
  input  logic [4:0]  DirWriteIDEX,
  input  logic        WriteRegIDEX,
  input  logic [1:0]  Flags,
  output logic [1:0]  MuxDireccionPC,
  output logic        StallPC,
  output logic        StallIFID,
  output logic        StallIDEX,
  output logic        FlushIFID,
  output logic        BubbleIDEX,
  output logic        BubbleEXMEM,
  output logic        MulBusy,
  output logic [15:0] StallCount,
  output logic [7:0]  FlushCount
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("MUL_LAT must be in 2..15");
  end

  typedef enum logic {RUN = 1'b0, MULWAIT = 1'b1} state_t;

  localparam logic [4:0] OP_BR_A = 5'b10100;
  localparam logic [4:0] OP_BR_B = 5'b10101;
  localparam logic [4:0] OP_MUL  = 5'b10110;
  localparam logic [4:0] OP_LD_A = 5'b01010;
  localparam logic [4:0] OP_LD_B = 5'b01011;
  localparam logic [4:0] OP_JMP  = 5'b10011;
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  logic branch_taken;
  logic load_use;

  assign branch_taken = ((OpCodeIDEXOUT == OP_BR_A) && (Flags == 2'b00 || Flags == 2'b10)) ||
                        ((OpCodeIDEXOUT == OP_BR_B) && (Flags == 2'b01));
  assign load_use = ((OpCodeIDEXOUT == OP_LD_A) || (OpCodeIDEXOUT == OP_LD_B)) && WriteRegIDEX &&
                    ((DirWriteIDEX == DirRegA) || (DirWriteIDEX == DirRegB));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    MuxDireccionPC = 2'b00;
    StallPC        = 1'b0;
    StallIFID      = 1'b0;
    StallIDEX      = 1'b0;
    FlushIFID      = 1'b0;
    BubbleIDEX     = 1'b0;
    BubbleEXMEM    = 1'b0;
    MulBusy        = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          MuxDireccionPC = 2'b10;
          FlushIFID      = 1'b1;
          BubbleIDEX     = 1'b1;
        end else if (OpCodeIDEXOUT == OP_MUL) begin
          StallPC     = 1'b1;
          StallIFID   = 1'b1;
          StallIDEX   = 1'b1;
          BubbleEXMEM = 1'b1;
          MulBusy     = 1'b1;
          state_d     = MULWAIT;
          cnt_d       = MUL_CNT_INIT;
        end else if (load_use) begin
          // A jump sitting in ID is held, not taken, and re-evaluates next cycle.
          StallPC    = 1'b1;
          StallIFID  = 1'b1;
          BubbleIDEX = 1'b1;
        end else if (OpcodeID == OP_JMP) begin
          MuxDireccionPC = 2'b01;
          FlushIFID      = 1'b1;
        end
      end
      MULWAIT: begin
        MulBusy = 1'b1;
        if (cnt_q != 4'd0) begin
          StallPC     = 1'b1;
          StallIFID   = 1'b1;
          StallIDEX   = 1'b1;
          BubbleEXMEM = 1'b1;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
    // Outputs must read idle for the whole time reset is held, even mid-multiply.
    if (!rst_n) begin
      MuxDireccionPC = 2'b00;
      StallPC        = 1'b0;
      StallIFID      = 1'b0;
      StallIDEX      = 1'b0;
      FlushIFID      = 1'b0;
      BubbleIDEX     = 1'b0;
      BubbleEXMEM    = 1'b0;
      MulBusy        = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallPC && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if ((MuxDireccionPC != 2'b00) && (flush_cnt_q != 8'hFF)) flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
